vx_tcu_tfr_join_pipe: RTL and testbench
=======================================

// Module: vx_tcu_tfr_join_pipe
// PURPOSE
//  Pipelined, flow-controlled join stage of the TCU FEDP datapath, placed between the split multiplier paths and the aligner/adder tree.
//  - Selects the F16, F8 or INT product path by fmt_s and appends the C-term as lane TCK.
//  - Reduces lane and C exceptions to a single flag set.
//  - Computes the max exponent across all TCK+1 terms for the downstream aligner.
//  - Two elastic register stages with valid/ready backpressure; optional C-term disable (c_en).
// PARAMETERS
//  N      2      multiplier groups; TCK = 2*N product lanes
//  TCK    2*N    product lanes per request
//  W      25     product significand width used in C exponent bias
//  WA     28     aligner accumulator width used in C exponent bias
//  EXP_W  10     exponent width, unsigned, biased
//  REQ_W  32     request-id width
// PORTS
//  clk         in   1               clock
//  reset_n     in   1               asynchronous active-low reset
//  valid_in    in   1               input request valid
//  ready_in    out  1               join can accept input
//  req_id_in   in   REQ_W           request tag
//  fmt_s       in   4               TCU format id
//  c_en        in   1               1: include C-term; 0: C treated as +0
//  c_val       in   32              C-term (FP32 or INT32 bits)
//  sig_f16     in   TCK*25          F16/BF16/TF32 path significands
//  exp_f16     in   TCK*EXP_W       F16/BF16/TF32 path exponents
//  exc_f16     in   TCK*fedp_excep_t  F16/BF16/TF32 path exceptions
//  sig_f8      in   TCK*25          FP8/BF8 path significands
//  exp_f8      in   TCK*EXP_W       FP8/BF8 path exponents
//  exc_f8      in   TCK*fedp_excep_t  FP8/BF8 path exceptions
//  sig_int     in   TCK*25          integer path products
//  valid_out   out  1               output valid
//  ready_out   in   1               downstream ready
//  req_id_out  out  REQ_W           tag of the output beat
//  sig_out     out  (TCK+1)*25      [TCK] = C-term, [TCK-1:0] = lanes
//  exp_out     out  (TCK+1)*EXP_W   per-term exponents
//  exp_max     out  EXP_W           max of exp_out over all TCK+1 terms
//  exc_out     out  fedp_excep_t    reduced {is_nan, is_inf, sign}
//  fmt_err     out  1               fmt_s not a supported/enabled format
// BEHAVIOUR
//  - Reset (async, reset_n=0): both stage valids=0, all data regs=0; every output reads 0; in-flight beats are dropped. Release is synchronous to clk.
//  - Pipeline: S1 registers the path mux, C-term and exception reduction; S2 registers the exp_max tree.
//  - Latency: exactly 2 cycles input->output when not stalled; throughput 1 beat/cycle.
//  - Handshake:
//    - adv2 = ready_out | ~v2; adv1 = adv2 | ~v1; ready_in = adv1.
//    - A transfer occurs when valid & ready are high on the same edge.
//    - A stalled stage holds all payload bits stable.
//    - valid_out never drops without a transfer.
//    - ready_in does not depend combinationally on valid_in.
//  - Path mux:
//    - FP16/BF16/TF32 -> F16 path; FP8/BF8 -> F8 path.
//    - I8/U8/I4/U4/MXI8 -> sig_int, with lane exps=0 and lane exc=0.
//    - Format-enable defines gate which ids are accepted.
//    - Any other id: fmt_err=1, sig/exp/exc/exp_max=0; the beat still flows through with its req_id.
//  - C-term:
//    - INT format: sig = c_val[24:0], exp = 0, no exceptions.
//    - FP format: sig = {c_val[31], 1'b1, c_val[22:0]}; exp = c_val[30:23] - (W-1) + (WA-1) + 128, mod 2^EXP_W.
//    - Exponent forced to 0 when C is zero or denormal (exponent field 0).
//    - c_en=0: C sig=0, exp=0, excluded from exceptions.
//  - Exceptions (FP only):
//    - has_pos/has_neg = any +Inf / any -Inf over lanes and C.
//    - nan = any lane NaN | C NaN | (has_pos & has_neg).
//    - inf = (has_pos | has_neg) & ~nan.
//    - sign = has_neg & ~has_pos.
//  - exp_max: unsigned max over the TCK+1 exp_out values; 0 in INT mode and when all terms are zero.
//  - Simultaneous accept and output in one cycle is legal.
//  - A bubble (v1=0) is squeezed out when S2 is stalled.
// TESTING
//  - Reset, then FP16 beat: all lanes exp=0x120, c_val=0x3F800000 (1.0), c_en=1 -> 2 cycles later:
//    - sig_out[TCK] = 25'h0800000, exp_out[TCK] = 0x102, exp_max = 0x120, exc = 0.
//  - Infinity cancellation:
//    - lane0 +Inf, C = 0xFF800000 (-Inf) -> exc_out.is_nan=1, is_inf=0.
//    - lane0 -Inf only -> is_inf=1, sign=1.
//  - I8 with c_val=0x00000005, c_en=0 -> C sig=0, all exps=0, exp_max=0, exc=0; sig_out lanes equal sig_int.
//  - Backpressure:
//    - Hold ready_out=0 for 5 cycles while streaming ids 1..4 -> ready_in drops after 2 beats are accepted.
//    - After release, output order is 1,2,3,4 with no loss or duplication; payload is stable while stalled.
//  - fmt_s=4'hF -> fmt_err=1, data zero, req_id preserved, latency 2.
//  - Assert reset_n mid-stream with 2 beats in flight -> valid_out=0 immediately; no stale beat after release.

Source files
------------

// File: rtl/vx_tcu_tfr_join_pipe.sv
// TCU FEDP join stage: selects the product path, appends the C-term as the
// last lane, folds exceptions and feeds the aligner with per-term exponents
// plus their maximum. Two elastic stages with valid/ready flow control.

package vx_tcu_tfr_join_pkg;

  localparam int unsigned SIG_W = 25;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic sign;
  } fedp_excep_t;

  localparam logic [3:0] FMT_FP16 = 4'd1;
  localparam logic [3:0] FMT_BF16 = 4'd2;
  localparam logic [3:0] FMT_FP8  = 4'd3;
  localparam logic [3:0] FMT_BF8  = 4'd4;
  localparam logic [3:0] FMT_TF32 = 4'd5;
  localparam logic [3:0] FMT_I8   = 4'd9;
  localparam logic [3:0] FMT_U8   = 4'd10;
  localparam logic [3:0] FMT_I4   = 4'd11;
  localparam logic [3:0] FMT_U4   = 4'd12;
  localparam logic [3:0] FMT_MXI8 = 4'd13;

endpackage

module vx_tcu_tfr_join_pipe
  import vx_tcu_tfr_join_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned TCK    = 2 * N,
  parameter int unsigned W      = 25,
  parameter int unsigned WA     = 28,
  parameter int unsigned EXP_W  = 10,
  parameter int unsigned REQ_W  = 32,
  // one enable bit per format id; unsupported ids are rejected regardless
  parameter logic [15:0] FMT_EN = 16'h3E3E
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic [REQ_W-1:0]           req_id_in,
  input  logic [3:0]                 fmt_s,
  input  logic                       c_en,
  input  logic [31:0]                c_val,
  input  logic [TCK*SIG_W-1:0]       sig_f16,
  input  logic [TCK*EXP_W-1:0]       exp_f16,
  input  fedp_excep_t [TCK-1:0]      exc_f16,
  input  logic [TCK*SIG_W-1:0]       sig_f8,
  input  logic [TCK*EXP_W-1:0]       exp_f8,
  input  fedp_excep_t [TCK-1:0]      exc_f8,
  input  logic [TCK*SIG_W-1:0]       sig_int,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [REQ_W-1:0]           req_id_out,
  output logic [(TCK+1)*SIG_W-1:0]   sig_out,
  output logic [(TCK+1)*EXP_W-1:0]   exp_out,
  output logic [EXP_W-1:0]           exp_max,
  output fedp_excep_t                exc_out,
  output logic                       fmt_err
);

  // FP32 C exponent rebased into the aligner's exponent frame
  localparam int C_BIAS = (int'(WA) - 1) - (int'(W) - 1) + 128;

  logic is_f16, is_f8, is_int, fmt_ok;
  logic sel_f16, sel_f8, sel_int;

  logic [TCK*SIG_W-1:0]  lane_sig;
  logic [TCK*EXP_W-1:0]  lane_exp;
  fedp_excep_t [TCK-1:0] lane_exc;

  logic [SIG_W-1:0] c_sig;
  logic [EXP_W-1:0] c_exp;
  logic             c_inf, c_nan;

  logic        has_pos, has_neg, any_nan;
  fedp_excep_t red_exc;

  logic adv1, adv2;

  logic                     v1;
  logic [REQ_W-1:0]         s1_id;
  logic [(TCK+1)*SIG_W-1:0] s1_sig;
  logic [(TCK+1)*EXP_W-1:0] s1_exp;
  fedp_excep_t              s1_exc;
  logic                     s1_err;
  logic [EXP_W-1:0]         s1_max_c;

  logic                     v2;
  logic [REQ_W-1:0]         s2_id;
  logic [(TCK+1)*SIG_W-1:0] s2_sig;
  logic [(TCK+1)*EXP_W-1:0] s2_exp;
  logic [EXP_W-1:0]         s2_max;
  fedp_excep_t              s2_exc;
  logic                     s2_err;

  // Format decode and enable gating
  always_comb begin
    is_f16  = (fmt_s == FMT_FP16) || (fmt_s == FMT_BF16) || (fmt_s == FMT_TF32);
    is_f8   = (fmt_s == FMT_FP8)  || (fmt_s == FMT_BF8);
    is_int  = (fmt_s == FMT_I8)   || (fmt_s == FMT_U8)   || (fmt_s == FMT_I4) ||
              (fmt_s == FMT_U4)   || (fmt_s == FMT_MXI8);
    fmt_ok  = FMT_EN[fmt_s] & (is_f16 | is_f8 | is_int);
    sel_f16 = is_f16 & fmt_ok;
    sel_f8  = is_f8  & fmt_ok;
    sel_int = is_int & fmt_ok;
  end

  // Product path mux; integer lanes carry no exponent or exceptions
  always_comb begin
    lane_sig = '0;
    lane_exp = '0;
    lane_exc = '0;
    if (sel_f16) begin
      lane_sig = sig_f16;
      lane_exp = exp_f16;
      lane_exc = exc_f16;
    end else if (sel_f8) begin
      lane_sig = sig_f8;
      lane_exp = exp_f8;
      lane_exc = exc_f8;
    end else if (sel_int) begin
      lane_sig = sig_int;
    end
  end

  // C-term formatting and FP32 special decode
  always_comb begin
    c_sig = '0;
    c_exp = '0;
    c_inf = 1'b0;
    c_nan = 1'b0;
    if (c_en && sel_int) begin
      c_sig = c_val[SIG_W-1:0];
    end else if (c_en && (sel_f16 || sel_f8)) begin
      c_sig = {c_val[31], 1'b1, c_val[22:0]};
      if (c_val[30:23] != 8'h00) begin
        c_exp = EXP_W'(c_val[30:23]) + EXP_W'(C_BIAS);
      end
      if (c_val[30:23] == 8'hFF) begin
        c_nan = |c_val[22:0];
        c_inf = ~|c_val[22:0];
      end
    end
  end

  // Fold lane and C exceptions; opposite infinities cancel to NaN
  always_comb begin
    has_pos = c_inf & ~c_val[31];
    has_neg = c_inf & c_val[31];
    any_nan = c_nan;
    for (int unsigned i = 0; i < TCK; i++) begin
      if (lane_exc[i].is_nan) begin
        any_nan = 1'b1;
      end else if (lane_exc[i].is_inf) begin
        if (lane_exc[i].sign) has_neg = 1'b1;
        else                  has_pos = 1'b1;
      end
    end
    red_exc.is_nan = any_nan | (has_pos & has_neg);
    red_exc.is_inf = (has_pos | has_neg) & ~red_exc.is_nan;
    red_exc.sign   = has_neg & ~has_pos;
  end

  // Elastic advance: a stage moves when it is empty or its consumer moves
  assign adv2     = ready_out | ~v2;
  assign adv1     = adv2 | ~v1;
  assign ready_in = adv1;

  // Stage 1: mux, C-term and exception registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1     <= 1'b0;
      s1_id  <= '0;
      s1_sig <= '0;
      s1_exp <= '0;
      s1_exc <= '0;
      s1_err <= 1'b0;
    end else if (adv1) begin
      v1 <= valid_in;
      if (valid_in) begin
        s1_id  <= req_id_in;
        s1_sig <= {c_sig, lane_sig};
        s1_exp <= {c_exp, lane_exp};
        s1_exc <= red_exc;
        s1_err <= ~fmt_ok;
      end
    end
  end

  // Max exponent across all terms of the stage-1 beat
  always_comb begin
    s1_max_c = '0;
    for (int unsigned i = 0; i < TCK + 1; i++) begin
      if (s1_exp[i*EXP_W +: EXP_W] > s1_max_c) s1_max_c = s1_exp[i*EXP_W +: EXP_W];
    end
  end

  // Stage 2: output registers including exp_max
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2     <= 1'b0;
      s2_id  <= '0;
      s2_sig <= '0;
      s2_exp <= '0;
      s2_max <= '0;
      s2_exc <= '0;
      s2_err <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s2_id  <= s1_id;
        s2_sig <= s1_sig;
        s2_exp <= s1_exp;
        s2_max <= s1_max_c;
        s2_exc <= s1_exc;
        s2_err <= s1_err;
      end
    end
  end

  assign valid_out  = v2;
  assign req_id_out = s2_id;
  assign sig_out    = s2_sig;
  assign exp_out    = s2_exp;
  assign exp_max    = s2_max;
  assign exc_out    = s2_exc;
  assign fmt_err    = s2_err;

endmodule

// File: tb/tb_vx_tcu_tfr_join_pipe.sv
// Bench for vx_tcu_tfr_join_pipe: directed scenarios plus a randomized
// stream scored against a behavioural model of the join stage.

module tb_vx_tcu_tfr_join_pipe;
  import vx_tcu_tfr_join_pkg::*;

  localparam int unsigned N     = 2;
  localparam int unsigned TCK   = 2 * N;
  localparam int unsigned EXP_W = 10;
  localparam int unsigned REQ_W = 32;
  localparam int unsigned SW    = 25;
  localparam int unsigned OSW   = (TCK + 1) * SW;
  localparam int unsigned OEW   = (TCK + 1) * EXP_W;

  typedef struct packed {
    logic [REQ_W-1:0]      id;
    logic [3:0]            fmt;
    logic                  c_en;
    logic [31:0]           c_val;
    logic [TCK*SW-1:0]     sig_f16;
    logic [TCK*SW-1:0]     sig_f8;
    logic [TCK*SW-1:0]     sig_int;
    logic [TCK*EXP_W-1:0]  exp_f16;
    logic [TCK*EXP_W-1:0]  exp_f8;
    fedp_excep_t [TCK-1:0] exc_f16;
    fedp_excep_t [TCK-1:0] exc_f8;
  } beat_t;

  typedef struct packed {
    logic [REQ_W-1:0] id;
    logic [OSW-1:0]   sig;
    logic [OEW-1:0]   exp;
    logic [EXP_W-1:0] emax;
    fedp_excep_t      exc;
    logic             err;
  } res_t;

  logic clk, reset_n, valid_in, ready_in, c_en, valid_out, ready_out, fmt_err;
  logic [REQ_W-1:0] req_id_in, req_id_out;
  logic [3:0] fmt_s;
  logic [31:0] c_val;
  logic [TCK*SW-1:0] sig_f16, sig_f8, sig_int;
  logic [TCK*EXP_W-1:0] exp_f16, exp_f8;
  fedp_excep_t [TCK-1:0] exc_f16, exc_f8;
  logic [OSW-1:0] sig_out;
  logic [OEW-1:0] exp_out;
  logic [EXP_W-1:0] exp_max;
  fedp_excep_t exc_out;

  int checks = 0;
  int errors = 0;

  vx_tcu_tfr_join_pipe #(.N(N), .EXP_W(EXP_W), .REQ_W(REQ_W)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in),
    .req_id_in(req_id_in), .fmt_s(fmt_s), .c_en(c_en), .c_val(c_val),
    .sig_f16(sig_f16), .exp_f16(exp_f16), .exc_f16(exc_f16),
    .sig_f8(sig_f8), .exp_f8(exp_f8), .exc_f8(exc_f8), .sig_int(sig_int),
    .valid_out(valid_out), .ready_out(ready_out), .req_id_out(req_id_out),
    .sig_out(sig_out), .exp_out(exp_out), .exp_max(exp_max),
    .exc_out(exc_out), .fmt_err(fmt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input beat_t b, input logic v);
    valid_in  = v;
    req_id_in = b.id;
    fmt_s     = b.fmt;
    c_en      = b.c_en;
    c_val     = b.c_val;
    sig_f16   = b.sig_f16;
    sig_f8    = b.sig_f8;
    sig_int   = b.sig_int;
    exp_f16   = b.exp_f16;
    exp_f8    = b.exp_f8;
    exc_f16   = b.exc_f16;
    exc_f8    = b.exc_f8;
  endtask

  function automatic res_t sample();
    res_t r;
    r.id = req_id_out; r.sig = sig_out; r.exp = exp_out;
    r.emax = exp_max; r.exc = exc_out; r.err = fmt_err;
    return r;
  endfunction

  // Behavioural model of one beat through the join
  function automatic res_t model(input beat_t b);
    res_t r;
    int kind, mx, f;
    bit pos, neg, nan;
    logic [SW-1:0] s;
    logic [EXP_W-1:0] e;
    fedp_excep_t x;
    r = '0; r.id = b.id; mx = 0; pos = 0; neg = 0; nan = 0;
    case (b.fmt)
      4'd1, 4'd2, 4'd5:                 kind = 1;
      4'd3, 4'd4:                       kind = 2;
      4'd9, 4'd10, 4'd11, 4'd12, 4'd13: kind = 3;
      default:                          kind = 0;
    endcase
    if (kind == 0) begin
      r.err = 1'b1;
      return r;
    end
    for (int i = 0; i < TCK; i++) begin
      if (kind == 1) begin
        s = b.sig_f16[i*SW +: SW]; e = b.exp_f16[i*EXP_W +: EXP_W]; x = b.exc_f16[i];
      end else if (kind == 2) begin
        s = b.sig_f8[i*SW +: SW]; e = b.exp_f8[i*EXP_W +: EXP_W]; x = b.exc_f8[i];
      end else begin
        s = b.sig_int[i*SW +: SW]; e = '0; x = '0;
      end
      r.sig[i*SW +: SW] = s;
      r.exp[i*EXP_W +: EXP_W] = e;
      if (int'(e) > mx) mx = int'(e);
      if (x.is_nan) nan = 1;
      else if (x.is_inf) begin
        if (x.sign) neg = 1; else pos = 1;
      end
    end
    if (b.c_en) begin
      if (kind == 3) begin
        r.sig[TCK*SW +: SW] = b.c_val[24:0];
      end else begin
        f = int'(b.c_val[30:23]);
        r.sig[TCK*SW +: SW] = {b.c_val[31], 1'b1, b.c_val[22:0]};
        e = (f == 0) ? '0 : EXP_W'((f - (25 - 1) + (28 - 1) + 128) % 1024);
        r.exp[TCK*EXP_W +: EXP_W] = e;
        if (int'(e) > mx) mx = int'(e);
        if (f == 255) begin
          if (b.c_val[22:0] != 0) nan = 1;
          else if (b.c_val[31]) neg = 1;
          else pos = 1;
        end
      end
    end
    r.exc.is_nan = nan | (pos & neg);
    r.exc.is_inf = (pos | neg) & ~r.exc.is_nan;
    r.exc.sign   = neg & ~pos;
    r.emax = EXP_W'(mx);
    return r;
  endfunction

  function automatic fedp_excep_t rand_exc();
    int k;
    k = int'($urandom_range(0, 15));
    case (k)
      0:       return 3'b100;
      1:       return 3'b010;
      2:       return 3'b011;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic beat_t rand_beat(input int id);
    beat_t b;
    logic [3:0] fmts [13];
    int k;
    fmts = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd0, 4'd15, 4'd7};
    b.id   = REQ_W'(id);
    b.fmt  = fmts[$urandom_range(0, 12)];
    b.c_en = ($urandom_range(0, 3) != 0);
    k = int'($urandom_range(0, 7));
    case (k)
      0:       b.c_val = 32'h7F800000;
      1:       b.c_val = 32'hFF800000;
      2:       b.c_val = 32'h7FC00001;
      3:       b.c_val = {1'($urandom), 8'h00, 23'($urandom)};
      default: b.c_val = $urandom;
    endcase
    for (int i = 0; i < TCK; i++) begin
      b.sig_f16[i*SW +: SW] = SW'($urandom);
      b.sig_f8[i*SW +: SW]  = SW'($urandom);
      b.sig_int[i*SW +: SW] = SW'($urandom);
      b.exp_f16[i*EXP_W +: EXP_W] = EXP_W'($urandom);
      b.exp_f8[i*EXP_W +: EXP_W]  = EXP_W'($urandom);
      b.exc_f16[i] = rand_exc();
      b.exc_f8[i]  = rand_exc();
    end
    return b;
  endfunction

  // Send one beat into an empty pipe and capture what emerges (no checking)
  task automatic one_beat(input beat_t b, output res_t got, output logic early, output logic vo);
    beat_t idle;
    idle = '0;
    @(negedge clk);
    ready_out = 1'b1;
    drive(b, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(idle, 1'b0);
    early = valid_out;
    @(posedge clk);
    @(negedge clk);
    vo  = valid_out;
    got = sample();
  endtask

  task automatic test_reset();
    beat_t idle;
    idle = '0;
    drive(idle, 1'b0);
    ready_out = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++;
    if (sample() !== res_t'(0)) begin errors++; $display("FAIL reset_data got=%h exp=0", sample()); end
    reset_n = 1'b1;
  endtask

  task automatic test_fp16_basic();
    beat_t b;
    res_t got;
    logic early, vo;
    b = rand_beat(32'h11);
    b.fmt = 4'd1; b.c_en = 1'b1; b.c_val = 32'h3F800000; b.exc_f16 = '0;
    for (int i = 0; i < TCK; i++) b.exp_f16[i*EXP_W +: EXP_W] = 10'h120;
    one_beat(b, got, early, vo);
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL fp16_latency1 got=%b exp=0", early); end
    checks++;
    if (vo !== 1'b1) begin errors++; $display("FAIL fp16_latency2 got=%b exp=1", vo); end
    checks++;
    if (got.sig[TCK*SW +: SW] !== 25'h0800000) begin
      errors++; $display("FAIL fp16_c_sig got=%h exp=0800000", got.sig[TCK*SW +: SW]);
    end
    checks++;
    if (got.exp[TCK*EXP_W +: EXP_W] !== 10'h102) begin
      errors++; $display("FAIL fp16_c_exp got=%h exp=102", got.exp[TCK*EXP_W +: EXP_W]);
    end
    checks++;
    if (got.emax !== 10'h120 || got.exc !== 3'b000) begin
      errors++; $display("FAIL fp16_max_exc got=%h/%b exp=120/000", got.emax, got.exc);
    end
    checks++;
    if (got !== model(b)) begin errors++; $display("FAIL fp16_full got=%h exp=%h", got, model(b)); end
  endtask

  task automatic test_inf_cancel();
    beat_t b;
    res_t got;
    logic early, vo;
    b = rand_beat(32'h21);
    b.fmt = 4'd1; b.c_en = 1'b1; b.c_val = 32'hFF800000; b.exc_f16 = '0;
    b.exc_f16[0] = 3'b010;
    one_beat(b, got, early, vo);
    checks++;
    if (vo !== 1'b1 || got.exc.is_nan !== 1'b1 || got.exc.is_inf !== 1'b0) begin
      errors++; $display("FAIL inf_cancel got=%b exc=%b exp nan=1 inf=0", vo, got.exc);
    end
    b.id = 32'h22; b.c_val = 32'h3F800000; b.exc_f16[0] = 3'b011;
    one_beat(b, got, early, vo);
    checks++;
    if (vo !== 1'b1 || got.exc !== 3'b011) begin
      errors++; $display("FAIL neg_inf got=%b exc=%b exp=011", vo, got.exc);
    end
  endtask

  task automatic test_int();
    beat_t b;
    res_t got;
    logic early, vo;
    b = rand_beat(32'h31);
    b.fmt = 4'd9; b.c_en = 1'b0; b.c_val = 32'h00000005;
    one_beat(b, got, early, vo);
    checks++;
    if (vo !== 1'b1 || got.sig !== {25'h0, b.sig_int}) begin
      errors++; $display("FAIL int_sig got=%h exp=%h", got.sig, {25'h0, b.sig_int});
    end
    checks++;
    if (got.exp !== '0 || got.emax !== '0 || got.exc !== 3'b000 || got.err !== 1'b0 || got.id !== 32'h31) begin
      errors++; $display("FAIL int_zero got=%h/%h/%b/%b exp=0/0/000/0", got.exp, got.emax, got.exc, got.err);
    end
  endtask

  task automatic test_fmt_err();
    beat_t b;
    res_t got, want;
    logic early, vo;
    b = rand_beat(32'hABCD1234);
    b.fmt = 4'hF;
    want = '0; want.id = 32'hABCD1234; want.err = 1'b1;
    one_beat(b, got, early, vo);
    checks++;
    if (early !== 1'b0 || vo !== 1'b1) begin
      errors++; $display("FAIL fmt_err_latency got=%b%b exp=01", early, vo);
    end
    checks++;
    if (got !== want) begin errors++; $display("FAIL fmt_err_data got=%h exp=%h", got, want); end
  endtask

  task automatic test_back_to_back();
    beat_t bs [6];
    beat_t idle;
    idle = '0;
    for (int i = 0; i < 6; i++) bs[i] = rand_beat(100 + i);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      ready_out = 1'b1;
      checks++;
      if (cyc >= 2 && cyc < 8) begin
        if (valid_out !== 1'b1 || sample() !== model(bs[cyc-2])) begin
          errors++; $display("FAIL b2b_beat%0d v=%b got=%h exp=%h", cyc - 2, valid_out, sample(), model(bs[cyc-2]));
        end
      end else if (valid_out !== 1'b0) begin
        errors++; $display("FAIL b2b_idle cyc%0d got=%b exp=0", cyc, valid_out);
      end
      if (cyc < 6) drive(bs[cyc], 1'b1);
      else drive(idle, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    beat_t bs [4];
    beat_t idle;
    res_t held, got;
    bit have_held;
    int idx, nout;
    idle = '0; idx = 0; nout = 0; have_held = 0; held = '0;
    for (int i = 0; i < 4; i++) bs[i] = rand_beat(i + 1);
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      ready_out = 1'b0;
      if (idx < 4) drive(bs[idx], 1'b1); else drive(idle, 1'b0);
      #1;
      if (valid_out) begin
        if (have_held) begin
          checks++;
          if (sample() !== held) begin errors++; $display("FAIL bp_stable got=%h exp=%h", sample(), held); end
        end else begin
          held = sample(); have_held = 1;
        end
      end
      if (valid_in && ready_in) idx++;
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    checks++;
    if (idx !== 2 || ready_in !== 1'b0) begin
      errors++; $display("FAIL bp_accept got=%0d ready=%b exp=2 ready=0", idx, ready_in);
    end
    checks++;
    if (held !== model(bs[0])) begin errors++; $display("FAIL bp_head got=%h exp=%h", held, model(bs[0])); end
    for (int cyc = 0; cyc < 20 && nout < 4; cyc++) begin
      @(negedge clk);
      ready_out = 1'b1;
      if (idx < 4) drive(bs[idx], 1'b1); else drive(idle, 1'b0);
      #1;
      if (valid_out) begin
        got = sample();
        checks++;
        if (got !== model(bs[nout])) begin
          errors++; $display("FAIL bp_order%0d got=%h exp=%h", nout, got, model(bs[nout]));
        end
        nout++;
      end
      if (valid_in && ready_in) idx++;
      @(posedge clk);
    end
    checks++;
    if (nout !== 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", nout); end
    @(negedge clk);
    drive(idle, 1'b0);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL bp_dup got=%b exp=0", valid_out); end
  endtask

  task automatic test_reset_midstream();
    beat_t idle;
    idle = '0;
    @(negedge clk);
    ready_out = 1'b1;
    drive(rand_beat(201), 1'b1);
    @(negedge clk);
    drive(rand_beat(202), 1'b1);
    @(posedge clk);
    #1;
    drive(idle, 1'b0);
    checks++;
    if (valid_out !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got=%b exp=1", valid_out); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || sample() !== res_t'(0)) begin
      errors++; $display("FAIL rst_mid_async v=%b got=%h exp=0", valid_out, sample());
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_mid_stale cyc%0d got=%b exp=0", cyc, valid_out); end
    end
  endtask

  task automatic test_random();
    res_t expq [$];
    int accq [$];
    beat_t b;
    beat_t idle;
    logic vin, rdy, exp_rdy, exp_vo;
    int k;
    idle = '0;
    for (k = 0; k < 420; k++) begin
      @(negedge clk);
      b = rand_beat(1000 + k);
      vin = (k < 400) && ($urandom_range(0, 9) < 7);
      rdy = (k >= 400) || ($urandom_range(0, 9) < 6);
      if (vin) drive(b, 1'b1); else drive(idle, 1'b0);
      ready_out = rdy;
      #1;
      exp_rdy = !(expq.size() >= 2 && !rdy);
      exp_vo  = (expq.size() > 0) && (k - accq[0] >= 2);
      checks++;
      if (ready_in !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc%0d got=%b exp=%b", k, ready_in, exp_rdy); end
      checks++;
      if (valid_out !== exp_vo) begin errors++; $display("FAIL rnd_valid cyc%0d got=%b exp=%b", k, valid_out, exp_vo); end
      if (valid_out && expq.size() > 0) begin
        checks++;
        if (sample() !== expq[0]) begin
          errors++; $display("FAIL rnd_data cyc%0d got=%h exp=%h", k, sample(), expq[0]);
        end
        if (rdy) begin
          void'(expq.pop_front());
          void'(accq.pop_front());
        end
      end
      if (vin && ready_in) begin
        expq.push_back(model(b));
        accq.push_back(k);
      end
    end
    checks++;
    if (expq.size() != 0) begin errors++; $display("FAIL rnd_drain got=%0d exp=0 pending", expq.size()); end
    @(negedge clk);
    drive(idle, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fp16_basic();
    test_inf_cancel();
    test_int();
    test_fmt_err();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
